// File: rtl/bit_serial_alu_ctrl.sv
// Sequencer for a shared 1-bit ALU slice: walks captured operands LSB-first over
// WIDTH cycles, collects the slice outputs and presents a held full-width result.
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             illegal,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [5:0]       slice_sel,
    output logic             slice_less,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, b_reg, shift_reg;
    logic [5:0]       funct_reg;
    logic [CW-1:0]    cnt_reg;
    logic             carry_reg;
    logic             cin_msb_reg, cout_msb_reg;
    logic             last_bit;
    logic             is_sub_like;
    logic             is_arith;
    logic             overflow_bit;

    function automatic logic is_legal(input logic [5:0] f);
        return (f == F_AND) || (f == F_OR) || (f == F_ADD) || (f == F_SUB) || (f == F_SLT);
    endfunction

    assign last_bit     = (cnt_reg == CW'(WIDTH - 1));
    assign is_sub_like  = (funct_reg == F_SUB) || (funct_reg == F_SLT);
    assign is_arith     = (funct_reg == F_ADD) || (funct_reg == F_SUB);
    assign overflow_bit = cin_msb_reg ^ cout_msb_reg;

    assign busy       = (state_reg != IDLE);
    assign done       = (state_reg == FIN);
    assign slice_less = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = is_legal(funct) ? RUN : FIN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_next = FIN;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Slice drives are live only while bits are being walked.
    always_comb begin
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_sel = 6'h00;
        if (state_reg == RUN) begin
            slice_a   = a_reg[cnt_reg];
            slice_b   = b_reg[cnt_reg];
            slice_sel = (funct_reg == F_SLT) ? F_SUB : funct_reg;
            slice_cin = (cnt_reg == '0) ? is_sub_like : carry_reg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_reg        <= '0;
            b_reg        <= '0;
            funct_reg    <= '0;
            shift_reg    <= '0;
            cnt_reg      <= '0;
            carry_reg    <= 1'b0;
            cin_msb_reg  <= 1'b0;
            cout_msb_reg <= 1'b0;
            result       <= '0;
            carry_out    <= 1'b0;
            overflow     <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        funct_reg <= funct;
                        cnt_reg   <= '0;
                        carry_reg <= 1'b0;
                    end
                end
                RUN: begin
                    shift_reg <= {slice_out, shift_reg[WIDTH-1:1]};
                    carry_reg <= slice_cout;
                    cnt_reg   <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        cin_msb_reg  <= slice_cin;
                        cout_msb_reg <= slice_cout;
                    end
                end
                FIN: begin
                    carry_out <= 1'b0;
                    overflow  <= 1'b0;
                    illegal   <= 1'b0;
                    if (!is_legal(funct_reg)) begin
                        result  <= '0;
                        illegal <= 1'b1;
                    end else if (funct_reg == F_SLT) begin
                        // Signed less-than: sign of A-B corrected by overflow.
                        result <= {{(WIDTH-1){1'b0}}, shift_reg[WIDTH-1] ^ overflow_bit};
                    end else begin
                        result <= shift_reg;
                        if (is_arith) begin
                            carry_out <= cout_msb_reg;
                            overflow  <= overflow_bit;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed bench for bit_serial_alu_ctrl (WIDTH=8) driving a behavioural 1-bit slice.
module tb_bit_serial_alu_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] op_a, op_b;
    logic         busy, done, carry_out, overflow, illegal;
    logic [W-1:0] result;
    logic         slice_a, slice_b, slice_cin, slice_less;
    logic [5:0]   slice_sel;
    logic         slice_out, slice_cout;

    int total = 0;
    int bad   = 0;
    int cyc;
    logic cin0;
    int done_seen;

    always #5 clk = ~clk;

    bit_serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .funct(funct),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out), .overflow(overflow),
        .illegal(illegal), .slice_a(slice_a), .slice_b(slice_b),
        .slice_cin(slice_cin), .slice_sel(slice_sel), .slice_less(slice_less),
        .slice_out(slice_out), .slice_cout(slice_cout)
    );

    // Behavioural 1-bit slice: inverts B for SUB.
    logic bb;
    always_comb begin
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        bb         = slice_b;
        case (slice_sel)
            6'h24: slice_out = slice_a & slice_b;
            6'h25: slice_out = slice_a | slice_b;
            6'h20, 6'h22: begin
                if (slice_sel == 6'h22) bb = ~slice_b;
                slice_out  = slice_a ^ bb ^ slice_cin;
                slice_cout = (slice_a & bb) | (slice_a & slice_cin) | (bb & slice_cin);
            end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op; returns the cycle index (1 = cycle after accept edge) where done is seen.
    // With poke set, a conflicting start is driven during RUN to show it is ignored.
    task automatic run_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke, output int c, output logic cin_first);
        @(negedge clk);
        start = 1'b1; funct = f; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        start = 1'b0; funct = 6'h20; op_a = ~a; op_b = ~b;
        cin_first = slice_cin;
        c = 1;
        while (!done && c < 40) begin
            start = (poke && c == 2);
            @(posedge clk);
            #1;
            c++;
        end
        start = 1'b0;
    endtask

    task automatic finish_op;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; funct = 6'h00; op_a = '0; op_b = '0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flags", {29'd0, carry_out, overflow, illegal}, 32'd0);
        chk("rst_slice", {25'd0, slice_a, slice_b, slice_cin, slice_less, slice_sel[2:0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD with signed overflow
        run_op(6'h20, 8'h7F, 8'h01, 1'b0, cyc, cin0);
        chk("add_latency", 32'(cyc), 32'd9);
        chk("add_busy_fin", 32'(busy), 32'd1);
        chk("add_cin0", 32'(cin0), 32'd0);
        finish_op();
        chk("add_result", 32'(result), 32'h80);
        chk("add_carry", 32'(carry_out), 32'd0);
        chk("add_ovf", 32'(overflow), 32'd1);
        chk("add_idle", {30'd0, busy, done}, 32'd0);

        // SUB with borrow
        run_op(6'h22, 8'h05, 8'h07, 1'b0, cyc, cin0);
        chk("sub1_cin0", 32'(cin0), 32'd1);
        finish_op();
        chk("sub1_result", 32'(result), 32'hFE);
        chk("sub1_flags", {30'd0, carry_out, overflow}, 32'd0);

        // SUB with signed overflow, no borrow
        run_op(6'h22, 8'h80, 8'h01, 1'b0, cyc, cin0);
        finish_op();
        chk("sub2_result", 32'(result), 32'h7F);
        chk("sub2_carry", 32'(carry_out), 32'd1);
        chk("sub2_ovf", 32'(overflow), 32'd1);

        // SLT cases
        run_op(6'h2A, 8'hFD, 8'h02, 1'b0, cyc, cin0);
        chk("slt1_cin0", 32'(cin0), 32'd1);
        finish_op();
        chk("slt1_result", 32'(result), 32'h01);
        chk("slt1_flags", {30'd0, carry_out, overflow}, 32'd0);
        run_op(6'h2A, 8'h7F, 8'h80, 1'b0, cyc, cin0);
        finish_op();
        chk("slt2_result", 32'(result), 32'h00);
        chk("slt2_flags", {30'd0, carry_out, overflow}, 32'd0);
        run_op(6'h2A, 8'h10, 8'h10, 1'b0, cyc, cin0);
        finish_op();
        chk("slt3_result", 32'(result), 32'h00);

        // AND with a conflicting start mid-RUN, then OR
        run_op(6'h24, 8'hF0, 8'h3C, 1'b1, cyc, cin0);
        chk("and_latency", 32'(cyc), 32'd9);
        finish_op();
        chk("and_result", 32'(result), 32'h30);
        chk("and_flags", {29'd0, carry_out, overflow, illegal}, 32'd0);
        chk("and_no_restart", 32'(busy), 32'd0);
        run_op(6'h25, 8'hF0, 8'h3C, 1'b0, cyc, cin0);
        finish_op();
        chk("or_result", 32'(result), 32'hFC);

        // Illegal funct
        run_op(6'h00, 8'h12, 8'h34, 1'b0, cyc, cin0);
        chk("ill_latency", 32'(cyc), 32'd1);
        chk("ill_sel", 32'(slice_sel), 32'd0);
        finish_op();
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_result", 32'(result), 32'h00);
        chk("ill_idle", 32'(busy), 32'd0);

        // Async reset in RUN cycle 4 after a nonzero result
        run_op(6'h25, 8'hA0, 8'h05, 1'b0, cyc, cin0);
        finish_op();
        chk("pre_rst_result", 32'(result), 32'hA5);
        @(negedge clk);
        start = 1'b1; funct = 6'h20; op_a = 8'h55; op_b = 8'h0F;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_slice", {26'd0, slice_a, slice_b, slice_cin, slice_sel[2:0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        chk("mid_rst_no_done", 32'(done_seen), 32'd0);
        run_op(6'h20, 8'h01, 8'h01, 1'b0, cyc, cin0);
        chk("post_rst_latency", 32'(cyc), 32'd9);
        finish_op();
        chk("post_rst_result", 32'(result), 32'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
